// File: rtl/target_render.sv
// target_render
//   Synthetic marker video source. Produces raster timing plus a compressed
//   3-bit pixel stream that shows up to four square targets. Each target has a
//   programmed centre and diameter. The stream feeds the marker detector
//   directly, with no colour compression stage in between.
//
//   Ports
//     clk_in          system clock
//     rst_in          synchronous active-high reset
//     wr_en_in        target register write strobe
//     wr_idx_in       target index 0..3
//     wr_x_in         target centre hcount
//     wr_y_in         target centre vcount
//     wr_diameter_in  target width in pixels
//     wr_valid_in     target enable
//     hcount_out      hcount of rgb_out
//     vcount_out      vcount of rgb_out
//     rgb_out         compressed pixel
//     line_start_out  high with the hcount_out==0 pixel
//     frame_start_out high with the (0,0) pixel
//     pixel_valid_out outputs carry a real pixel
//
//   Build option
//     TARGET_RING_EN  when defined, each target is a hollow square ring. The
//                     ring has a background-coloured centre of width
//                     2*(half>>1)+1. Pipeline latency does not change.
//
//   Latency: the outputs for internal position (h,v) appear two cycles later.
module target_render #(
    parameter int         H_TOTAL       = 1680,
    parameter int         V_TOTAL       = 1050,
    parameter int         H_ACTIVE      = 1280,
    parameter int         V_ACTIVE      = 1024,
    parameter logic [2:0] TARGET_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR     = 3'b000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        wr_en_in,
    input  logic [1:0]  wr_idx_in,
    input  logic [10:0] wr_x_in,
    input  logic [10:0] wr_y_in,
    input  logic [10:0] wr_diameter_in,
    input  logic        wr_valid_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic [2:0]  rgb_out,
    output logic        line_start_out,
    output logic        frame_start_out,
    output logic        pixel_valid_out
);

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);

    logic [10:0]      h_q, h_d, v_q, v_d;
    logic [3:0][10:0] stg_x_q, stg_x_d, stg_y_q, stg_y_d, stg_dia_q, stg_dia_d;
    logic [3:0]       stg_vld_q, stg_vld_d;
    logic [3:0][10:0] act_x_q, act_x_d, act_y_q, act_y_d, act_dia_q, act_dia_d;
    logic [3:0]       act_vld_q, act_vld_d;

    logic [10:0] s1_h_q, s1_h_d, s1_v_q, s1_v_d;
    logic [3:0]  s1_hit_q, s1_hit_d;
    logic        s1_act_q, s1_act_d, s1_ls_q, s1_ls_d, s1_fs_q, s1_fs_d;
    logic        s1_vld_q, s1_vld_d;

    logic [10:0] out_h_q, out_h_d, out_v_q, out_v_d;
    logic [2:0]  out_rgb_q, out_rgb_d;
    logic        out_ls_q, out_ls_d, out_fs_q, out_fs_d, out_vld_q, out_vld_d;

    logic        frame_wrap;

    // Raster counters, the staging register file and the frame latch.
    always_comb begin
        frame_wrap = (h_q == H_LAST) && (v_q == V_LAST);

        h_d = h_q + 11'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
        end

        // The copy reads the staging values from before this edge's write.
        // A write in the same cycle therefore waits for the next frame.
        act_x_d   = act_x_q;
        act_y_d   = act_y_q;
        act_dia_d = act_dia_q;
        act_vld_d = act_vld_q;
        if (frame_wrap) begin
            act_x_d   = stg_x_q;
            act_y_d   = stg_y_q;
            act_dia_d = stg_dia_q;
            act_vld_d = stg_vld_q;
        end

        stg_x_d   = stg_x_q;
        stg_y_d   = stg_y_q;
        stg_dia_d = stg_dia_q;
        stg_vld_d = stg_vld_q;
        if (wr_en_in) begin
            stg_x_d[wr_idx_in]   = wr_x_in;
            stg_y_d[wr_idx_in]   = wr_y_in;
            stg_dia_d[wr_idx_in] = wr_diameter_in;
            stg_vld_d[wr_idx_in] = wr_valid_in;
        end
    end

    // Per-target distance compare. The differences are 12-bit signed, so a
    // centre near 0 or beyond the active area cannot wrap.
    logic [3:0][11:0] diff_x, diff_y, mag_x, mag_y, half;
    logic [3:0]       hit;

    always_comb begin
        diff_x = '0;
        diff_y = '0;
        mag_x  = '0;
        mag_y  = '0;
        half   = '0;
        hit    = '0;
        for (int i = 0; i < 4; i++) begin
            diff_x[i] = {1'b0, h_q} - {1'b0, act_x_q[i]};
            diff_y[i] = {1'b0, v_q} - {1'b0, act_y_q[i]};
            mag_x[i]  = diff_x[i][11] ? 12'd0 - diff_x[i] : diff_x[i];
            mag_y[i]  = diff_y[i][11] ? 12'd0 - diff_y[i] : diff_y[i];
            half[i]   = {1'b0, act_dia_q[i]} >> 1;
            hit[i]    = act_vld_q[i] && (act_dia_q[i] != '0) &&
                        (mag_x[i] <= half[i]) && (mag_y[i] <= half[i]);
`ifdef TARGET_RING_EN
            if ((mag_x[i] <= (half[i] >> 1)) && (mag_y[i] <= (half[i] >> 1)))
                hit[i] = 1'b0;
`endif
        end
    end

    // Stage 1 registers the compares. Stage 2 merges the hits, selects the colour and drives the outputs.
    always_comb begin
        s1_h_d   = h_q;
        s1_v_d   = v_q;
        s1_hit_d = hit;
        s1_act_d = (h_q < H_ACT) && (v_q < V_ACT);
        s1_ls_d  = (h_q == '0);
        s1_fs_d  = (h_q == '0) && (v_q == '0);
        s1_vld_d = 1'b1;

        out_h_d   = s1_h_q;
        out_v_d   = s1_v_q;
        out_rgb_d = ((|s1_hit_q) && s1_act_q) ? TARGET_COLOUR : BG_COLOUR;
        out_ls_d  = s1_ls_q;
        out_fs_d  = s1_fs_q;
        out_vld_d = s1_vld_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            h_q       <= '0;
            v_q       <= '0;
            stg_x_q   <= '0;
            stg_y_q   <= '0;
            stg_dia_q <= '0;
            stg_vld_q <= '0;
            act_x_q   <= '0;
            act_y_q   <= '0;
            act_dia_q <= '0;
            act_vld_q <= '0;
            s1_h_q    <= '0;
            s1_v_q    <= '0;
            s1_hit_q  <= '0;
            s1_act_q  <= 1'b0;
            s1_ls_q   <= 1'b0;
            s1_fs_q   <= 1'b0;
            s1_vld_q  <= 1'b0;
            out_h_q   <= '0;
            out_v_q   <= '0;
            out_rgb_q <= '0;
            out_ls_q  <= 1'b0;
            out_fs_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            stg_x_q   <= stg_x_d;
            stg_y_q   <= stg_y_d;
            stg_dia_q <= stg_dia_d;
            stg_vld_q <= stg_vld_d;
            act_x_q   <= act_x_d;
            act_y_q   <= act_y_d;
            act_dia_q <= act_dia_d;
            act_vld_q <= act_vld_d;
            s1_h_q    <= s1_h_d;
            s1_v_q    <= s1_v_d;
            s1_hit_q  <= s1_hit_d;
            s1_act_q  <= s1_act_d;
            s1_ls_q   <= s1_ls_d;
            s1_fs_q   <= s1_fs_d;
            s1_vld_q  <= s1_vld_d;
            out_h_q   <= out_h_d;
            out_v_q   <= out_v_d;
            out_rgb_q <= out_rgb_d;
            out_ls_q  <= out_ls_d;
            out_fs_q  <= out_fs_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign hcount_out      = out_h_q;
    assign vcount_out      = out_v_q;
    assign rgb_out         = out_rgb_q;
    assign line_start_out  = out_ls_q;
    assign frame_start_out = out_fs_q;
    assign pixel_valid_out = out_vld_q;

endmodule

// File: tb/tb_target_render.sv
// Self-checking bench for target_render on a reduced raster (40x30, active 32x24).
// An expected-pixel model derives each pixel from the target rules with plain integer arithmetic.
module tb_target_render;

    localparam int HT = 40;
    localparam int VT = 30;
    localparam int HA = 32;
    localparam int VA = 24;
    localparam int FRAME = HT * VT;

`ifdef TARGET_RING_EN
    localparam int TGT1 = 96;
    localparam int CLIP = 25;
    localparam int OVL  = 72;
`else
    localparam int TGT1 = 121;
    localparam int CLIP = 44;
    localparam int OVL  = 78;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        wr_en_in = 1'b0;
    logic [1:0]  wr_idx_in = '0;
    logic [10:0] wr_x_in = '0, wr_y_in = '0, wr_diameter_in = '0;
    logic        wr_valid_in = 1'b0;
    logic [10:0] hcount_out, vcount_out;
    logic [2:0]  rgb_out;
    logic        line_start_out, frame_start_out, pixel_valid_out;

    target_render #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .wr_en_in(wr_en_in), .wr_idx_in(wr_idx_in),
        .wr_x_in(wr_x_in), .wr_y_in(wr_y_in), .wr_diameter_in(wr_diameter_in),
        .wr_valid_in(wr_valid_in), .hcount_out(hcount_out), .vcount_out(vcount_out),
        .rgb_out(rgb_out), .line_start_out(line_start_out),
        .frame_start_out(frame_start_out), .pixel_valid_out(pixel_valid_out)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // Model state: the internal raster position, the staging and active target sets,
    // and a two-deep delay line of expected output words {valid,fs,ls,rgb,h,v}.
    int mh = 0, mv = 0;
    int stg_x[4], stg_y[4], stg_d[4];
    bit stg_v[4];
    int act_x[4], act_y[4], act_d[4];
    bit act_v[4];
    logic [27:0] e1 = '0, e2 = '0;

    int  cur_tgt = 0, cur_ls = 0, last_tgt = 0, last_ls = 0;
    bit  fs_seen = 0;

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic logic [2:0] exp_pix(input int h, input int v);
        bit any = 0;
        for (int i = 0; i < 4; i++) begin
            int dx = iabs(h - act_x[i]);
            int dy = iabs(v - act_y[i]);
            int hf = act_d[i] / 2;
            bit in_sq = act_v[i] && (act_d[i] != 0) && (dx <= hf) && (dy <= hf);
`ifdef TARGET_RING_EN
            if (dx <= hf / 2 && dy <= hf / 2) in_sq = 0;
`endif
            if (in_sq) any = 1;
        end
        return (any && h < HA && v < VA) ? 3'b111 : 3'b000;
    endfunction

    task automatic step();
        @(posedge clk_in);
        if (rst_in) begin
            mh = 0; mv = 0; e1 = '0; e2 = '0;
            for (int i = 0; i < 4; i++) begin
                stg_x[i] = 0; stg_y[i] = 0; stg_d[i] = 0; stg_v[i] = 0;
                act_x[i] = 0; act_y[i] = 0; act_d[i] = 0; act_v[i] = 0;
            end
        end else begin
            e2 = e1;
            e1 = {1'b1, (mh == 0 && mv == 0), (mh == 0), exp_pix(mh, mv), 11'(mh), 11'(mv)};
            if (mh == HT - 1 && mv == VT - 1)
                for (int i = 0; i < 4; i++) begin
                    act_x[i] = stg_x[i]; act_y[i] = stg_y[i];
                    act_d[i] = stg_d[i]; act_v[i] = stg_v[i];
                end
            if (wr_en_in) begin
                stg_x[wr_idx_in] = int'(wr_x_in);
                stg_y[wr_idx_in] = int'(wr_y_in);
                stg_d[wr_idx_in] = int'(wr_diameter_in);
                stg_v[wr_idx_in] = wr_valid_in;
            end
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) mv = 0;
            end
        end
        #1;
        chk("pix", 32'({pixel_valid_out, frame_start_out, line_start_out, rgb_out,
                        hcount_out, vcount_out}), 32'(e2));
        if (frame_start_out) begin
            last_tgt = cur_tgt; last_ls = cur_ls;
            cur_tgt = 0; cur_ls = 0; fs_seen = 1;
        end
        if (pixel_valid_out && rgb_out == 3'b111) cur_tgt++;
        if (line_start_out) cur_ls++;
    endtask

    task automatic finish_frame();
        int n = 0;
        fs_seen = 0;
        while (!fs_seen && n < FRAME + 8) begin
            step();
            n++;
        end
        chk("frame_timeout", 32'(fs_seen), 32'd1);
    endtask

    task automatic write_now(input int idx, input int x, input int y, input int d, input bit vld);
        wr_en_in = 1'b1;
        wr_idx_in = 2'(idx);
        wr_x_in = 11'(x);
        wr_y_in = 11'(y);
        wr_diameter_in = 11'(d);
        wr_valid_in = vld;
        step();
        wr_en_in = 1'b0;
    endtask

    task automatic write_at(input int idx, input int x, input int y, input int d, input bit vld,
                            input int th, input int tv);
        int n = 0;
        while (!(mh == th && mv == tv) && n < 2 * FRAME) begin
            step();
            n++;
        end
        chk("wr_wait", 32'(mh == th && mv == tv), 32'd1);
        write_now(idx, x, y, d, vld);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_out", 32'({pixel_valid_out, frame_start_out, line_start_out, rgb_out,
                            hcount_out, vcount_out}), 32'd0);
        rst_in = 1'b0;
        chk("vld_c1", 32'(pixel_valid_out), 32'd0);
        step();
        chk("vld_c2", 32'(pixel_valid_out), 32'd0);
        step();
        chk("fs_c3", 32'(frame_start_out), 32'd1);
        chk("pos_c3", 32'({hcount_out, vcount_out}), 32'd0);
        chk("vld_c3", 32'(pixel_valid_out), 32'd1);

        // Empty frame.
        finish_frame();
        chk("empty_tgt", 32'(last_tgt), 32'd0);
        chk("empty_ls", 32'(last_ls), 32'(VT));

        // Single target, visible from the following frame.
        write_at(0, 10, 8, 10, 1, 5, 20);
        finish_frame();
        chk("t1_wrframe", 32'(last_tgt), 32'd0);
        finish_frame();
        chk("t1_next", 32'(last_tgt), 32'(TGT1));

        // Move mid-frame, then rewrite on the (0,0) cycle.
        write_at(0, 20, 8, 10, 1, 0, 12);
        finish_frame();
        chk("mv_cur", 32'(last_tgt), 32'(TGT1));
        finish_frame();
        chk("mv_next", 32'(last_tgt), 32'(TGT1));
        write_at(0, 12, 8, 10, 1, 0, 0);
        repeat (3) begin
            finish_frame();
            chk("mv00", 32'(last_tgt), 32'(TGT1));
        end

        // Clipping and zero diameter.
        write_at(0, 0, 0, 0, 0, 5, 5);
        write_now(1, 2, 0, 8, 1);
        write_now(2, HA - 1, VA - 1, 4, 1);
        write_now(3, 10, 10, 0, 1);
        finish_frame();
        finish_frame();
        chk("clip_tgt", 32'(last_tgt), 32'(CLIP));
        chk("clip_ls", 32'(last_ls), 32'(VT));

        // Overlap gives the union.
        write_at(1, 10, 10, 6, 1, 5, 5);
        write_now(2, 13, 12, 6, 1);
        write_now(3, 0, 0, 0, 0);
        finish_frame();
        finish_frame();
        chk("ovl_tgt", 32'(last_tgt), 32'(OVL));

        // Random writes at random times; the model checks every pixel.
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 300)) step();
            write_now($urandom_range(0, 3), $urandom_range(0, HT + 4), $urandom_range(0, VT + 4),
                      $urandom_range(0, 14), 1'($urandom_range(0, 1)));
        end
        finish_frame();
        finish_frame();
        finish_frame();

        // A one-cycle reset mid-frame.
        begin
            int n = 0;
            while (mv != 18 && n < 2 * FRAME) begin
                step();
                n++;
            end
            chk("rst_wait", 32'(mv == 18), 32'd1);
        end
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("rst_mid_out", 32'({pixel_valid_out, rgb_out, hcount_out, vcount_out}), 32'd0);
        step();
        chk("rst_vld", 32'(pixel_valid_out), 32'd0);
        step();
        chk("rst_fs", 32'(frame_start_out), 32'd1);
        finish_frame();
        chk("rst_tgt", 32'(last_tgt), 32'd0);
        chk("rst_ls", 32'(last_ls), 32'(VT));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
